// File: rtl/cart_bus_initiator_pkg.sv
// Shared constants for the cart register bus initiator: FSM encoding, halfword
// select values, memory map landmarks and register word offsets.
package cart_bus_initiator_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_WR_REQ  = 2'd3;

    localparam logic HALF_UPPER = 1'b0;
    localparam logic HALF_LOWER = 1'b1;

    // Words at or above this base are FIFO-backed and pop on every bus read.
    localparam logic [10:0] MEM_USB_FIFO_BASE = 11'h400;

    localparam logic [10:0] REG_STATUS   = 11'h000;
    localparam logic [10:0] REG_COMMAND  = 11'h001;
    localparam logic [10:0] REG_DATA     = 11'h002;
    localparam logic [10:0] REG_ID       = 11'h003;

    function automatic logic [15:0] select_half(input logic [31:0] word, input logic half);
        return (half == HALF_UPPER) ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/cart_bus_initiator.sv
// Converts PI halfword accesses into 32-bit register bus transactions, with
// write assembly, a one-word read buffer and a read ack timeout.
module cart_bus_initiator
    import cart_bus_initiator_pkg::*;
#(
    parameter logic [7:0] ACK_TIMEOUT = 8'd15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pi_address_load,
    input  logic [11:0] i_pi_address,
    input  logic        i_pi_read,
    input  logic        i_pi_write,
    input  logic [15:0] i_pi_data,
    output logic [15:0] o_pi_data,
    output logic        o_pi_done,
    output logic        o_pi_busy,
    output logic        o_request,
    output logic        o_write,
    input  logic        i_busy,
    input  logic        i_ack,
    output logic [10:0] o_address,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic [1:0]  o_dbg_state
);

    // Bus handshake: a transaction is accepted on the edge where o_request is
    // high and i_busy is low; read data is taken on the first i_ack afterwards.

    logic [1:0]  state_q,     state_d;
    logic [11:0] addr_q,      addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [10:0] buf_word_q,  buf_word_d;
    logic [15:0] buf_lo_q,    buf_lo_d;
    logic [15:0] upper_q,     upper_d;
    logic        pending_q,   pending_d;
    logic [7:0]  timer_q,     timer_d;
    logic [15:0] pi_data_q,   pi_data_d;
    logic        pi_done_q,   pi_done_d;
    logic        pi_busy_q,   pi_busy_d;
    logic        request_q,   request_d;
    logic        write_q,     write_d;
    logic [10:0] address_q,   address_d;
    logic [31:0] data_q,      data_d;

    logic [10:0] cur_word;
    logic        cur_half;

    assign cur_word = addr_q[11:1];
    assign cur_half = addr_q[0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_lo_d    = buf_lo_q;
        upper_d     = upper_q;
        pending_d   = pending_q;
        timer_d     = timer_q;
        pi_data_d   = pi_data_q;
        pi_done_d   = 1'b0;
        request_d   = request_q;
        write_d     = write_q;
        address_d   = address_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_pi_address_load) begin
                    addr_d      = i_pi_address;
                    buf_valid_d = 1'b0;
                    pending_d   = 1'b0;
                end else if (i_pi_write) begin
                    buf_valid_d = 1'b0;
                    if (cur_half == HALF_UPPER) begin
                        upper_d   = i_pi_data;
                        pending_d = 1'b1;
                        pi_done_d = 1'b1;
                        addr_d    = addr_q + 12'd1;
                    end else begin
                        data_d    = {pending_q ? upper_q : 16'h0000, i_pi_data};
                        address_d = cur_word;
                        request_d = 1'b1;
                        write_d   = 1'b1;
                        state_d   = ST_WR_REQ;
                    end
                end else if (i_pi_read) begin
                    // Lower half of an already fetched word never touches the bus.
                    if (cur_half == HALF_LOWER && buf_valid_q && buf_word_q == cur_word) begin
                        pi_data_d = buf_lo_q;
                        pi_done_d = 1'b1;
                        addr_d    = addr_q + 12'd1;
                    end else begin
                        address_d = cur_word;
                        request_d = 1'b1;
                        write_d   = 1'b0;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (!i_busy) begin
                    request_d = 1'b0;
                    timer_d   = 8'd0;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (i_ack) begin
                    buf_valid_d = 1'b1;
                    buf_word_d  = address_q;
                    buf_lo_d    = i_data[15:0];
                    pi_data_d   = select_half(i_data, cur_half);
                    pi_done_d   = 1'b1;
                    addr_d      = addr_q + 12'd1;
                    state_d     = ST_IDLE;
                end else if (timer_q == 8'(ACK_TIMEOUT - 8'd1)) begin
                    buf_valid_d = 1'b0;
                    pi_data_d   = 16'hFFFF;
                    pi_done_d   = 1'b1;
                    addr_d      = addr_q + 12'd1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_WR_REQ: begin
                if (!i_busy) begin
                    request_d   = 1'b0;
                    write_d     = 1'b0;
                    pi_done_d   = 1'b1;
                    pending_d   = 1'b0;
                    buf_valid_d = 1'b0;
                    addr_d      = addr_q + 12'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                request_d = 1'b0;
                write_d   = 1'b0;
            end
        endcase

        pi_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 12'd0;
            buf_valid_q <= 1'b0;
            buf_word_q  <= 11'd0;
            buf_lo_q    <= 16'd0;
            upper_q     <= 16'd0;
            pending_q   <= 1'b0;
            timer_q     <= 8'd0;
            pi_data_q   <= 16'd0;
            pi_done_q   <= 1'b0;
            pi_busy_q   <= 1'b0;
            request_q   <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= 11'd0;
            data_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_word_q  <= buf_word_d;
            buf_lo_q    <= buf_lo_d;
            upper_q     <= upper_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            pi_data_q   <= pi_data_d;
            pi_done_q   <= pi_done_d;
            pi_busy_q   <= pi_busy_d;
            request_q   <= request_d;
            write_q     <= write_d;
            address_q   <= address_d;
            data_q      <= data_d;
        end
    end

    assign o_pi_data   = pi_data_q;
    assign o_pi_done   = pi_done_q;
    assign o_pi_busy   = pi_busy_q;
    assign o_request   = request_q;
    assign o_write     = write_q;
    assign o_address   = address_q;
    assign o_data      = data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Bench for cart_bus_initiator: directed steps plus randomized PI traffic
// against a transaction-level reference model and a bus responder.
module tb_cart_bus_initiator;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pi_address_load = 1'b0;
    logic [11:0] i_pi_address = 12'd0;
    logic        i_pi_read = 1'b0;
    logic        i_pi_write = 1'b0;
    logic [15:0] i_pi_data = 16'd0;
    logic [15:0] o_pi_data;
    logic        o_pi_done;
    logic        o_pi_busy;
    logic        o_request;
    logic        o_write;
    logic        i_busy = 1'b0;
    logic        i_ack = 1'b0;
    logic [10:0] o_address;
    logic [31:0] o_data;
    logic [31:0] i_data = 32'd0;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected bus transactions {write, word, write data}.
    logic [43:0] exp_q[$];

    // Reference model state (PI-level view of the initiator).
    logic [11:0] m_addr;
    logic        m_buf_valid;
    logic [10:0] m_buf_word;
    logic [31:0] m_buf_data;
    logic        m_pending;
    logic [15:0] m_upper;
    logic [31:0] ref_mem [2048];
    logic [31:0] resp_mem [2048];

    cart_bus_initiator #(.ACK_TIMEOUT(8'd15)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_pi_address_load(i_pi_address_load), .i_pi_address(i_pi_address),
        .i_pi_read(i_pi_read), .i_pi_write(i_pi_write), .i_pi_data(i_pi_data),
        .o_pi_data(o_pi_data), .o_pi_done(o_pi_done), .o_pi_busy(o_pi_busy),
        .o_request(o_request), .o_write(o_write), .i_busy(i_busy), .i_ack(i_ack),
        .o_address(o_address), .o_data(o_data), .i_data(i_data),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fifo_next(input logic [31:0] v);
        return v + 32'h0101_0101;
    endfunction

    task automatic model_reset();
        m_addr = 12'd0; m_buf_valid = 1'b0; m_buf_word = 11'd0;
        m_buf_data = 32'd0; m_pending = 1'b0; m_upper = 16'd0;
    endtask

    task automatic pi_load(input logic [11:0] a);
        @(negedge clk);
        i_pi_address_load = 1'b1; i_pi_address = a;
        @(negedge clk);
        i_pi_address_load = 1'b0;
        m_addr = a; m_buf_valid = 1'b0; m_pending = 1'b0;
    endtask

    // One PI access; the bench also plays the bus responder cycle by cycle.
    task automatic pi_access(input int kind, input logic [15:0] wdata, input int busy_n,
                             input int ack_dly, input bit no_ack, input string tag);
        logic [10:0] w;
        logic        h;
        logic [15:0] exp_data;
        logic [31:0] rdata;
        int exp_lat, exp_req, n_req, c, done_c, busy_left, ack_wait;
        bit prev_req, accepted, acked, acc_write;
        logic [10:0] acc_addr;
        logic [15:0] obs_data;

        w = m_addr[11:1];
        h = m_addr[0];
        exp_data = 16'd0;
        exp_req = 0;
        if (kind == K_READ) begin
            if (h == 1'b1 && m_buf_valid && m_buf_word == w) begin
                exp_data = m_buf_data[15:0];
                exp_lat = 1;
            end else begin
                exp_req = 1;
                exp_q.push_back({1'b0, w, 32'h0});
                if (no_ack) begin
                    exp_data = 16'hFFFF;
                    exp_lat = 2 + busy_n + TIMEOUT;
                    m_buf_valid = 1'b0;
                end else begin
                    rdata = ref_mem[w];
                    if (w >= 11'h400) ref_mem[w] = fifo_next(rdata);
                    exp_data = h ? rdata[15:0] : rdata[31:16];
                    exp_lat = 3 + busy_n + ack_dly;
                    m_buf_valid = 1'b1; m_buf_word = w; m_buf_data = rdata;
                end
            end
        end else begin
            m_buf_valid = 1'b0;
            if (h == 1'b0) begin
                m_upper = wdata; m_pending = 1'b1; exp_lat = 1;
            end else begin
                exp_req = 1;
                exp_q.push_back({1'b1, w, m_pending ? m_upper : 16'h0000, wdata});
                ref_mem[w] = {m_pending ? m_upper : 16'h0000, wdata};
                m_pending = 1'b0;
                exp_lat = 2 + busy_n;
            end
        end
        m_addr = m_addr + 12'd1;

        @(negedge clk);
        if (kind == K_READ) i_pi_read = 1'b1;
        else begin i_pi_write = 1'b1; i_pi_data = wdata; end
        c = 0; done_c = -1; n_req = 0; prev_req = 0; accepted = 0; acked = 0;
        busy_left = busy_n; ack_wait = ack_dly; acc_write = 0; acc_addr = 11'd0;
        obs_data = 16'd0;
        while (c < 60 && done_c < 0) begin
            @(negedge clk);
            c++;
            i_pi_read = 1'b0; i_pi_write = 1'b0; i_busy = 1'b0; i_ack = 1'b0;
            if (o_pi_done) begin
                done_c = c; obs_data = o_pi_data;
            end else if (o_request) begin
                if (!prev_req) begin
                    n_req++;
                    check({tag, "_busy_flag"}, 64'(o_pi_busy), 64'd1);
                    if (exp_q.size() > 0)
                        check({tag, "_bus_txn"},
                              64'({o_write, o_address, o_write ? o_data : 32'h0}),
                              64'(exp_q.pop_front()));
                    else
                        check({tag, "_unexpected_txn"}, 64'(n_req), 64'd0);
                end
                if (busy_left > 0) begin
                    i_busy = 1'b1; busy_left--;
                end else begin
                    accepted = 1; acc_write = o_write; acc_addr = o_address;
                    if (o_write) resp_mem[o_address] = o_data;
                end
            end else if (accepted && !acc_write && !acked && !no_ack) begin
                if (ack_wait == 0) begin
                    i_ack = 1'b1; i_data = resp_mem[acc_addr]; acked = 1;
                    if (acc_addr >= 11'h400) resp_mem[acc_addr] = fifo_next(resp_mem[acc_addr]);
                end else ack_wait--;
            end
            prev_req = o_request;
        end
        check({tag, "_done_latency"}, 64'(done_c), 64'(exp_lat));
        check({tag, "_bus_count"}, 64'(n_req), 64'(exp_req));
        if (kind == K_READ) check({tag, "_rdata"}, 64'(obs_data), 64'(exp_data));
        if (exp_q.size() != 0) begin
            check({tag, "_leftover_txn"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [11:0] la;
        int r;
        for (int i = 0; i < 2048; i++) begin
            rv = $urandom;
            ref_mem[i] = rv; resp_mem[i] = rv;
        end
        ref_mem[2] = 32'h5336_3461; resp_mem[2] = 32'h5336_3461;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({o_pi_data, o_pi_done, o_pi_busy, o_request, o_write, o_address, o_dbg_state}),
              64'd0);
        check("reset_odata", 64'(o_data), 64'd0);
        i_reset = 1'b0;

        // Word read split into two halves, second served from the buffer.
        pi_load(12'h004);
        pi_access(K_READ, 16'h0, 0, 0, 0, "rd_upper");
        pi_access(K_READ, 16'h0, 0, 0, 0, "rd_lower_hit");

        // Two halfwords assembled into one bus write.
        pi_load(12'h000);
        pi_access(K_WRITE, 16'h0001, 0, 0, 0, "wr_upper");
        pi_access(K_WRITE, 16'h001F, 0, 0, 0, "wr_word");

        // FIFO region: one bus read per word.
        pi_load(12'h800);
        for (int i = 0; i < 4; i++) pi_access(K_READ, 16'h0, 0, 0, 0, "fifo_rd");

        // Responder stall and missing ack.
        pi_load(12'h020);
        pi_access(K_READ, 16'h0, 3, 0, 0, "rd_busy3");
        pi_access(K_READ, 16'h0, 0, 0, 1, "rd_timeout");
        pi_access(K_READ, 16'h0, 0, 0, 0, "rd_after_timeout");

        // Address wrap from 12'hFFF.
        pi_load(12'hFFF);
        pi_access(K_READ, 16'h0, 0, 1, 0, "rd_top");
        pi_access(K_READ, 16'h0, 0, 0, 0, "rd_wrapped");

        // Ack while idle must not complete anything.
        @(negedge clk);
        i_ack = 1'b1; i_data = 32'hDEAD_BEEF;
        @(negedge clk);
        i_ack = 1'b0;
        check("idle_ack_no_done", 64'(o_pi_done), 64'd0);

        // Reset while a word write is stalled.
        pi_load(12'h010);
        pi_access(K_WRITE, 16'hABCD, 0, 0, 0, "rst_wr_upper");
        @(negedge clk);
        i_pi_write = 1'b1; i_pi_data = 16'h1234;
        @(negedge clk);
        i_pi_write = 1'b0; i_busy = 1'b1;
        check("rst_req_up", 64'(o_request), 64'd1);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0; i_busy = 1'b0;
        check("rst_req_drop", 64'({o_request, o_pi_done, o_pi_busy}), 64'd0);
        @(negedge clk);
        check("rst_no_done", 64'(o_pi_done), 64'd0);
        model_reset();
        pi_access(K_READ, 16'h0, 0, 0, 0, "rst_rd_word0");
        pi_access(K_WRITE, 16'h5678, 0, 0, 0, "rst_wr_no_pending");

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                case ($urandom_range(0, 2))
                    0: la = 12'($urandom);
                    1: la = 12'h800 + 12'($urandom_range(0, 7));
                    default: la = 12'hFFE;
                endcase
                pi_load(la);
            end else if (r <= 5) begin
                pi_access(K_READ, 16'h0, $urandom_range(0, 3), $urandom_range(0, 2),
                          ($urandom_range(0, 9) == 0), "rand_rd");
            end else begin
                pi_access(K_WRITE, 16'($urandom), $urandom_range(0, 3), 0, 0, "rand_wr");
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_bus_initiator.md
# cart_bus_initiator

Initiator for the cart register bus: converts 16-bit halfword accesses from the synchronized N64 PI front end into 32-bit register-bus transactions toward the cart control register block. It owns halfword assembly for writes, halfword splitting for reads, request/busy/ack sequencing and an ack timeout. It sits between the PI front end and the register block; the register block is the responder.

## Interface
Parameters:
- ACK_TIMEOUT, 8'd15, cycles to wait for i_ack after an accepted read before returning dummy data

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_pi_address_load  in  1  pulse: load halfword address
- i_pi_address  in  12  halfword address; [11:1] word address, [0] halfword select (0 = upper half, bits 31:16)
- i_pi_read  in  1  pulse: read halfword at current address
- i_pi_write  in  1  pulse: write i_pi_data at current address
- i_pi_data  in  16  write halfword
- o_pi_data  out  16  read halfword, valid with o_pi_done
- o_pi_done  out  1  one-cycle pulse: access complete
- o_pi_busy  out  1  high while not IDLE
- o_request  out  1  bus request
- o_write  out  1  bus direction, 1 = write
- i_busy  in  1  responder stall
- i_ack  in  1  read data valid
- o_address  out  11  word address
- o_data  out  32  write word
- i_data  in  32  read word

## Operation
- Reset: all outputs 0; address 0; read buffer invalid; pending upper half cleared; state IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Strobes accepted only in IDLE; strobes while o_pi_busy are dropped (front end must not issue them). Priority if coincident in IDLE: address_load > write > read.
- Address load: latches address, invalidates read buffer, discards any pending upper-half write.
- Every completed read or write access increments the halfword address by 1 (11:0 wraps 12'hFFF → 12'h000).
- Read, half 0: always goes to RD_REQ (o_request=1, o_write=0, o_address=word). Never served from buffer.
- Read, half 1: if buffer valid and buffer word == current word, return i_data_buf[15:0] with no bus transaction; else RD_REQ. Guarantees one bus read per word, so FIFO-region reads (word ≥ 11'h400) pop exactly once per word.
- RD_REQ: hold o_request until sampled with !i_busy, then RD_WAIT. RD_WAIT: on i_ack latch i_data into buffer (valid, tagged with word), drive selected half on o_pi_data, pulse o_pi_done, go IDLE.
- Timeout: RD_WAIT counter; after ACK_TIMEOUT cycles without i_ack, o_pi_data = 16'hFFFF, o_pi_done, buffer invalid, IDLE.
- Write, half 0: store in upper-half register, mark pending, pulse o_pi_done, no bus transaction.
- Write, half 1: o_data = {pending ? upper : 16'h0000, i_pi_data}; WR_REQ with o_write=1. Accepted when o_request && !i_busy; then o_pi_done, clear pending, invalidate buffer, IDLE. No ack expected for writes.
- Any write invalidates the read buffer.
- i_ack outside RD_WAIT ignored.
- Reset mid-transaction: state to IDLE, o_request drops next edge; in-flight ack ignored.

## Timing
- All outputs registered.
- Read miss, i_busy=0: strobe edge T0, o_request high T1, ack at T2, o_pi_done + data T3; o_request low from T2.
- Each cycle of i_busy adds one cycle before acceptance.
- Buffer hit and half-0 write: o_pi_done one cycle after strobe.
- Word write, i_busy=0: o_request T1, accepted at T1 edge, o_pi_done T2.
- o_pi_busy high from the cycle after a bus-bound strobe until o_pi_done cycle (inclusive deassert next edge).

## Structure
- Shared package: state enum, halfword select constants, MEM_USB_FIFO_BASE (11'h400), register word offsets.
- Single module; timeout counter inline, no sub-module.

## Test plan
- Load 12'h004 (word 2, half 0), read, read -> one bus read at 11'h002, i_data 32'h5336_3461 returns 16'h5336 then 16'h3461; o_address never asserted for the second.
- Write 16'h0001 then 16'h001F at word 0 -> single write, o_data 32'h0001_001F, o_address 0, two o_pi_done pulses.
- FIFO region: load 12'h800, four reads -> exactly two bus reads (11'h400, 11'h401).
- i_busy high 3 cycles during RD_REQ -> o_request held 4 cycles, done at T6.
- No ack -> 16'hFFFF with done after ACK_TIMEOUT=15 cycles in RD_WAIT.
- Reset asserted during WR_REQ -> o_request 0 next cycle, no o_pi_done, pending cleared.
